// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the three-requester SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned N_REQ      = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned REQ_DITHER = 0;
  localparam int unsigned REQ_LOAD   = 1;
  localparam int unsigned REQ_RDBK   = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_RD1   = 2'd2,
    ARB_RD2   = 2'd3
  } arb_state_t;

  // Arbitration decision: one-hot winner plus its access direction.
  typedef struct packed {
    logic [N_REQ-1:0] sel;
    logic             wr;
  } arb_pick_t;

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// One-hot winner selection: starved requesters first, then fixed index priority.
module arb_priority_pick
  import sram_port_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] starved,
  output logic [N_REQ-1:0] win
);

  logic [N_REQ-1:0] cand;

  // Lowest set bit of the candidate set; index 0 (dither) has highest priority.
  always_comb begin
    cand = (|(req & starved)) ? (req & starved) : req;
    win  = cand & N_REQ'(~cand + N_REQ'(1));
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter for dither engine, MCU load and MCU readback paths.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wren,
  output logic              sram_rden,
  input  logic [DATA_W-1:0] sram_q,
  output logic              busy
);

  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             armed;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [N_REQ-1:0] starved;
  logic [N_REQ-1:0] win;
  logic [N_REQ-1:0] owner;
  arb_pick_t        pick;
  logic             take;

  arb_priority_pick u_pick (
    .req     (req),
    .starved (starved),
    .win     (win)
  );

  assign pick = {win, |(win & we)};
  // armed stays low until the first edge after reset so no grant lands on that edge.
  assign take = armed && (state == ARB_IDLE) && (|win);

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      starved[i] = (cnt[i] == STARVE_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (take) state_nxt = pick.wr ? ARB_WRITE : ARB_RD1;
      ARB_WRITE: state_nxt = ARB_IDLE;
      ARB_RD1:   state_nxt = ARB_RD2;
      ARB_RD2:   state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Grant and SRAM drive follow the winner in the grant cycle itself.
  always_comb begin
    gnt        = '0;
    sram_wren  = 1'b0;
    sram_rden  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    busy       = (state != ARB_IDLE);
    if (take) begin
      gnt       = pick.sel;
      sram_wren = pick.wr;
      sram_rden = !pick.wr;
      if (pick.sel[REQ_DITHER]) begin
        sram_addr  = addr0;
        sram_wdata = pick.wr ? wdata0 : '0;
      end else if (pick.sel[REQ_LOAD]) begin
        sram_addr  = addr1;
        sram_wdata = pick.wr ? wdata1 : '0;
      end else if (pick.sel[REQ_RDBK]) begin
        sram_addr  = addr2;
        sram_wdata = pick.wr ? wdata2 : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed  <= 1'b0;
      owner  <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      armed  <= 1'b1;
      if (take) owner <= pick.sel;
      rvalid <= (state == ARB_RD2) ? owner : '0;
      if (state == ARB_RD2) rdata <= sram_q;
    end
  end

  // Per-requester wait counters saturate at the starvation limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!req[i] || gnt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != STARVE_CNT) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a 2-cycle-latency SRAM model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req, we, gnt, rvalid;
  logic [15:0] addr0, addr1, addr2, sram_addr;
  logic [7:0]  wdata0, wdata1, wdata2, rdata, sram_wdata, sram_q;
  logic        sram_wren, sram_rden, busy;

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(15)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wren(sram_wren), .sram_rden(sram_rden),
    .sram_q(sram_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; bit wr; logic [15:0] addr; logic [7:0] wdata; int gap; } g_exp_t;
  typedef struct { int idx; logic [7:0] data; } r_exp_t;
  g_exp_t gq[$];
  r_exp_t rq[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int last_gnt_cyc = 0;
  int last_rd_cyc = 0;
  bit free_run = 1'b0;
  int free_rd = 0;
  int free_rv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: q valid two cycles after rden.
  logic [7:0]  mem [0:65535];
  logic        p1_v;
  logic [15:0] p1_a;
  always @(posedge clk) begin
    if (sram_wren) mem[sram_addr] <= sram_wdata;
    p1_v <= sram_rden;
    p1_a <= sram_addr;
    if (p1_v) sram_q <= mem[p1_a];
  end

  // Monitor: invariants every cycle, scoreboard pops on gnt and rvalid.
  always @(negedge clk) begin
    g_exp_t e;
    r_exp_t r;
    logic ok;
    cyc_n++;
    if (rst) begin
      ok = $onehot0(gnt) && $onehot0(rvalid) && !(sram_wren && sram_rden) &&
           ((gnt != 3'b000) || (!sram_wren && !sram_rden && sram_addr == 16'h0 && sram_wdata == 8'h0));
      chk("invariant", 32'(ok), 32'd1);
      if (gnt != 3'b000) begin
        if (free_run) begin
          if (sram_rden) free_rd++;
        end else if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          e = gq.pop_front();
          chk("gnt", 32'(gnt), 32'(3'b001 << e.idx));
          chk("wren", 32'(sram_wren), 32'(e.wr));
          chk("rden", 32'(sram_rden), 32'(!e.wr));
          chk("addr", 32'(sram_addr), 32'(e.addr));
          if (e.wr) chk("wdata", 32'(sram_wdata), 32'(e.wdata));
          if (e.gap != 0) chk("gnt_gap", cyc_n - last_gnt_cyc, e.gap);
        end
        if (sram_rden) last_rd_cyc = cyc_n;
        last_gnt_cyc = cyc_n;
      end
      if (rvalid != 3'b000) begin
        if (free_run) begin
          free_rv++;
        end else if (rq.size() == 0) begin
          chk("unexpected_rvalid", 32'(rvalid), 32'd0);
        end else begin
          r = rq.pop_front();
          chk("rvalid", 32'(rvalid), 32'(3'b001 << r.idx));
          chk("rdata", 32'(rdata), 32'(r.data));
          chk("rd_latency", cyc_n - last_rd_cyc, 3);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (gq.size() != 0 || rq.size() != 0); k++) cyc(1);
    chk("drain_gnt_q", gq.size(), 0);
    chk("drain_rd_q", rq.size(), 0);
    cyc(4);
  endtask

  task automatic push_g(input int idx, input bit wr, input logic [15:0] a, input logic [7:0] d, input int gap);
    g_exp_t e;
    e.idx = idx; e.wr = wr; e.addr = a; e.wdata = d; e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic push_r(input int idx, input logic [7:0] d);
    r_exp_t r;
    r.idx = idx; r.data = d;
    rq.push_back(r);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'hA5;
    mem[16'h0300] = 8'h5A;
    sram_q = 8'h00;
    p1_v = 1'b0;
    p1_a = 16'h0;
    rst = 1'b0;
    req = 3'b111; we = 3'b111;
    addr0 = 16'h0001; addr1 = 16'h0002; addr2 = 16'h0003;
    wdata0 = 8'h01; wdata1 = 8'h02; wdata2 = 8'h03;

    // Reset with all requests active: everything quiet.
    cyc(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wren", 32'(sram_wren), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);

    // Release mid-cycle with a dither write pending: no grant before first edge.
    req = 3'b001; we = 3'b001; addr0 = 16'h0005; wdata0 = 8'h55;
    push_g(0, 1, 16'h0005, 8'h55, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("post_rst_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    cyc(1); req = 3'b000;
    drain();

    // Dither and load writes together: dither first, load two cycles later.
    addr0 = 16'h0010; wdata0 = 8'h11; addr1 = 16'h0020; wdata1 = 8'h22;
    we = 3'b011; req = 3'b011;
    push_g(0, 1, 16'h0010, 8'h11, 0);
    push_g(1, 1, 16'h0020, 8'h22, 2);
    cyc(1); req = 3'b010;
    chk("busy_write", 32'(busy), 32'd1);
    cyc(2); req = 3'b000;
    drain();

    // Dither read of A5; inputs scrambled after grant.
    addr0 = 16'h0100; we = 3'b000; req = 3'b001;
    push_g(0, 0, 16'h0100, 8'h00, 0);
    push_r(0, 8'hA5);
    cyc(1); req = 3'b000; addr0 = 16'hFFFF; we = 3'b111;
    chk("busy_rd1", 32'(busy), 32'd1);
    drain();

    // Load write then readback read of the same word.
    addr1 = 16'h0200; wdata1 = 8'h3C; addr2 = 16'h0200; we = 3'b010; req = 3'b110;
    push_g(1, 1, 16'h0200, 8'h3C, 0);
    push_g(2, 0, 16'h0200, 8'h00, 2);
    push_r(2, 8'h3C);
    cyc(1); req = 3'b100;
    cyc(2); req = 3'b000;
    drain();

    // Readback request only during a load write: silently dropped.
    addr1 = 16'h0210; wdata1 = 8'h44; we = 3'b010; req = 3'b010;
    push_g(1, 1, 16'h0210, 8'h44, 0);
    cyc(1); req = 3'b100; we = 3'b000; addr2 = 16'h0300;
    cyc(1); req = 3'b000;
    drain();

    // Continuous dither writes: readback wins once its counter hits 15.
    addr0 = 16'h0400; wdata0 = 8'h77; addr2 = 16'h0300; we = 3'b001; req = 3'b101;
    for (int i = 0; i < 8; i++) push_g(0, 1, 16'h0400, 8'h77, (i == 0) ? 0 : 2);
    push_g(2, 0, 16'h0300, 8'h00, 2);
    push_r(2, 8'h5A);
    push_g(0, 1, 16'h0400, 8'h77, 3);
    cyc(20); req = 3'b000;
    drain();

    // Reset during RD1: outputs clear at once, read discarded.
    addr0 = 16'h0100; we = 3'b000; req = 3'b001;
    push_g(0, 0, 16'h0100, 8'h00, 0);
    cyc(1); req = 3'b000; rst = 1'b0;
    #1;
    chk("midrd_busy", 32'(busy), 32'd0);
    chk("midrd_rvalid", 32'(rvalid), 32'd0);
    chk("midrd_rdata", 32'(rdata), 32'd0);
    chk("midrd_rden", 32'(sram_rden), 32'd0);
    cyc(3);
    req = 3'b001;
    push_g(0, 0, 16'h0100, 8'h00, 0);
    push_r(0, 8'hA5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midrd_post_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    cyc(1); req = 3'b000;
    drain();

    // Random traffic: invariants plus read grant/rvalid pairing.
    free_run = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      req = 3'($urandom); we = 3'($urandom);
      addr0 = 16'($urandom); addr1 = 16'($urandom); addr2 = 16'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom); wdata2 = 8'($urandom);
      cyc(1);
    end
    req = 3'b000;
    cyc(6);
    free_run = 1'b0;
    chk("rand_rd_match", free_rv, free_rd);
    chk("rand_rd_seen", 32'(free_rd != 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
